interrupt_ctrl: RTL and testbench
=================================

Name: interrupt_ctrl

Overview:
Parametrised multi-source interrupt controller for the CPU core. It generalises the single timer-interrupt block to NUM_SRC sources, with:
- per-source pending latches and a writable enable mask;
- fixed lowest-index-wins priority;
- a registered one-cycle jump pulse carrying a source vector;
- an in-service state held until the CPU signals return-from-interrupt.

It sits between the peripherals (timer, UART, GPIO, …) and the control unit / PC-select logic.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..32).
- MASK_RST, all ones (NUM_SRC bits), reset value of the enable mask.
- VEC_W, derived localparam = max(1, clog2(NUM_SRC)), width of the vector output. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- irq_in  in  NUM_SRC  raw source requests; bit i = source i, bit 0 = timer.
- mask_we  in  1  write enable for the mask register.
- mask_wdata  in  NUM_SRC  new mask value; 1 = source enabled.
- clear_we  in  1  pending-clear strobe.
- clear_mask  in  NUM_SRC  bits to clear in pending when clear_we = 1.
- ret  in  1  one-cycle pulse from the CPU: return from ISR.
- status  out  NUM_SRC  pending register, unmasked view.
- mask  out  NUM_SRC  current mask register.
- jump  out  1  registered one-cycle pulse: branch to ISR.
- vector  out  VEC_W  index of the source being serviced.
- in_service  out  1  high from the jump cycle until ret is accepted.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - pending = 0, mask = MASK_RST, state = IDLE;
  - jump = 0, vector = 0, in_service = 0;
  - edge-detect history = 0 (when compiled in).
  - Reset mid-service abandons the service; no jump follows reset.
- Pending update, per bit i, each edge:
  - If clear_we & clear_mask[i]: pending[i] <= 0. Clear wins over a simultaneous set.
  - Else if event[i]: pending[i] <= 1.
  - Else if the auto-clear below hits bit i: pending[i] <= 0.
  - Else hold.
  - event[i] = irq_in[i] in level mode.
- Mask write: mask <= mask_wdata on the edge where mask_we = 1; takes effect for arbitration on the following cycle.
- Masking gates arbitration only. Masked sources still latch into pending and remain visible on status.
- Arbitration: req = pending & mask. Winner = lowest set index of req.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if req != 0 → REQ; vector <= winner. Otherwise stay in IDLE.
  - REQ (exactly one cycle): jump = 1, in_service = 1, pending[vector] auto-cleared on this edge (subject to the clear/set precedence above). Next state SERVICE. ret is ignored in REQ.
  - SERVICE: jump = 0, in_service = 1, vector held. New events keep latching into pending. On ret = 1 → IDLE and in_service <= 0.
  - ret in IDLE is ignored.
- Back-to-back servicing: if req != 0 in the cycle after returning to IDLE, REQ follows. Minimum spacing between jump pulses is therefore 3 cycles after ret.
- Latency: irq_in high at edge N → pending set at N → REQ entered at edge N+1 → jump visible during cycle N+1..N+2. This is 2 edges from request to jump pulse when idle.
- If the winning source is masked, or its pending bit is cleared, while in REQ/SERVICE, the service in progress is unaffected.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro INTERRUPT_CTRL_EDGE_DETECT_EN.
- Defined: event[i] = irq_in[i] & ~irq_d[i], where irq_d is a registered copy of irq_in, reset to 0. A source held high latches pending only once per rising edge.
- Undefined: level mode, event[i] = irq_in[i]. A held source re-sets pending every cycle, so it will re-trigger after ret unless the source is deasserted.

Decomposition:
- Package interrupt_pkg holds:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2);
  - the VEC_W computation function;
  - the default source index constant TIMER_IRQ = 0.
- One sub-module: irq_prio_enc (parametrised NUM_SRC), a combinational lowest-index priority encoder with outputs valid and index.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with irq_in = 8'hFF → status = 0, mask = 8'hFF, jump = 0, in_service = 0. Release rst → jump pulse with vector = 0 exactly 2 edges later.
- Priority: irq_in = 8'b1010_0000 for one cycle → one jump with vector = 5. Pending then shows 8'b1000_0000. ret → next jump with vector = 7. ret → status = 0, no further jump.
- Mask: write mask = 8'hFE, pulse irq_in[0] → status[0] = 1, no jump. Write mask = 8'hFF → jump with vector = 0 two edges later.
- Clear vs set: clear_we = 1, clear_mask = 8'h04 in the same cycle as irq_in[2] = 1 → status[2] = 0 and no jump.
- Service hold: during SERVICE, pulse irq_in[1] → no jump while in_service = 1. After ret: jump with vector = 1. ret during IDLE → no state change.
- Edge mode, with INTERRUPT_CTRL_EDGE_DETECT_EN defined: hold irq_in[3] high for 20 cycles → exactly one jump, vector = 3. Without the macro, the same stimulus → a new jump after every ret.

Source files
------------

// File: rtl/interrupt_pkg.sv
// interrupt_pkg: shared definitions for the interrupt controller slice.
//   - state_t    : controller FSM encoding (IDLE / REQ / SERVICE)
//   - vec_width  : width of the source-index vector, max(1, clog2(n))
//   - TIMER_IRQ  : index of the timer source (also the reset vector)
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int TIMER_IRQ = 0;

  // A single source still needs a 1-bit vector port.
  function automatic int vec_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins.
// Ports:
//   req    in  NUM_SRC  request vector
//   valid  out 1        any request bit set
//   index  out VEC_W    index of the lowest set request bit (0 when none)
module irq_prio_enc
  import interrupt_pkg::*;
#(
  parameter int NUM_SRC = 8,
  localparam int VEC_W  = vec_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [VEC_W-1:0]   index
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = |req;
    index = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: multi-source interrupt controller with per-source pending
// latches, a writable enable mask, lowest-index-wins arbitration, a one-cycle
// jump pulse carrying the winning vector, and an in-service hold until ret.
//
// Ports:
//   clk         in  1        system clock, rising edge
//   rst         in  1        synchronous active-low reset
//   irq_in      in  NUM_SRC  raw source requests (bit 0 = timer)
//   mask_we     in  1        mask write enable
//   mask_wdata  in  NUM_SRC  new mask value (1 = enabled)
//   clear_we    in  1        pending clear strobe
//   clear_mask  in  NUM_SRC  pending bits to clear
//   ret         in  1        return-from-interrupt pulse
//   status      out NUM_SRC  pending register (unmasked)
//   mask        out NUM_SRC  mask register
//   jump        out 1        one-cycle branch-to-ISR pulse
//   vector      out VEC_W    index of the source being serviced
//   in_service  out 1        high from the jump cycle until ret is accepted
//
// Build option: define INTERRUPT_CTRL_EDGE_DETECT_EN to latch pending only on
// rising edges of irq_in; otherwise a high level re-sets pending every cycle.
module interrupt_ctrl
  import interrupt_pkg::*;
#(
  parameter int                   NUM_SRC  = 8,
  parameter logic [NUM_SRC-1:0]   MASK_RST = '1,
  localparam int                  VEC_W    = vec_width(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               clear_we,
  input  logic [NUM_SRC-1:0] clear_mask,
  input  logic               ret,
  output logic [NUM_SRC-1:0] status,
  output logic [NUM_SRC-1:0] mask,
  output logic               jump,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service
);

  state_t             state_reg, state_next;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] mask_reg;
  logic [VEC_W-1:0]   vector_reg, vector_next;
  logic [NUM_SRC-1:0] irq_event;
  logic [NUM_SRC-1:0] req;
  logic               req_valid;
  logic [VEC_W-1:0]   winner;
  logic               auto_clr;

  // ---------------------------------------------------------------- events
`ifdef INTERRUPT_CTRL_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] irq_d_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_d_reg <= '0;
    end else begin
      irq_d_reg <= irq_in;
    end
  end

  assign irq_event = irq_in & ~irq_d_reg;
`else
  assign irq_event = irq_in;
`endif

  // ------------------------------------------------------------ arbitration
  // Masking only gates arbitration; pending still records masked sources.
  assign req = pending_reg & mask_reg;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (req),
    .valid (req_valid),
    .index (winner)
  );

  // --------------------------------------------------------------- pending
  // The serviced bit is auto-cleared on the REQ edge, but an explicit clear
  // or a fresh event on that same edge takes precedence.
  assign auto_clr = (state_reg == REQ);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      assign pending_next[gi] =
          (clear_we && clear_mask[gi])                    ? 1'b0 :
          irq_event[gi]                                   ? 1'b1 :
          (auto_clr && (vector_reg == VEC_W'(gi)))        ? 1'b0 :
                                                            pending_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= '0;
      mask_reg    <= MASK_RST;
    end else begin
      pending_reg <= pending_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      vector_reg <= VEC_W'(TIMER_IRQ);
    end else begin
      state_reg  <= state_next;
      vector_reg <= vector_next;
    end
  end

  // The vector is captured only when leaving IDLE, so later mask writes or
  // pending clears cannot disturb a service already under way.
  always_comb begin
    state_next  = state_reg;
    vector_next = vector_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          state_next  = REQ;
          vector_next = winner;
        end
      end
      REQ: begin
        state_next = SERVICE;
      end
      SERVICE: begin
        if (ret) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so no input reaches them
  // combinationally.
  always_comb begin
    jump       = 1'b0;
    in_service = 1'b0;
    case (state_reg)
      REQ: begin
        jump       = 1'b1;
        in_service = 1'b1;
      end
      SERVICE: begin
        in_service = 1'b1;
      end
      default: begin
        jump       = 1'b0;
        in_service = 1'b0;
      end
    endcase
  end

  assign status = pending_reg;
  assign mask   = mask_reg;
  assign vector = vector_reg;

endmodule

// File: tb/tb_interrupt_ctrl.sv
module tb_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       clear_we;
  logic [7:0] clear_mask;
  logic       ret;
  logic [7:0] status;
  logic [7:0] mask;
  logic       jump;
  logic [2:0] vector;
  logic       in_service;

  int n_assert = 0;
  int n_fail   = 0;
  int jumps_seen;
  int model_jumps;

  // Reference model: pending/mask bit vectors plus "cycles since the jump
  // was issued" (-1 = not servicing, 0 = jump cycle, 1+ = servicing).
  logic [7:0] m_pend, m_mask, m_prev;
  int         m_since_jump;
  int         m_vec;

  interrupt_ctrl #(.NUM_SRC(8), .MASK_RST(8'hFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .clear_we   (clear_we),
    .clear_mask (clear_mask),
    .ret        (ret),
    .status     (status),
    .mask       (mask),
    .jump       (jump),
    .vector     (vector),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Advance one clock edge, update the model from the inputs seen at that
  // edge, then compare every output against it.
  task automatic step(input string tag);
    logic [7:0] ev, nxt, req;
    @(posedge clk);
    if (!rst) begin
      m_pend = 8'h00; m_mask = 8'hFF; m_prev = 8'h00;
      m_since_jump = -1; m_vec = 0;
    end else begin
`ifdef INTERRUPT_CTRL_EDGE_DETECT_EN
      ev = irq_in & ~m_prev;
`else
      ev = irq_in;
`endif
      req = m_pend & m_mask;
      for (int i = 0; i < 8; i++) begin
        if (clear_we && clear_mask[i])            nxt[i] = 1'b0;
        else if (ev[i])                           nxt[i] = 1'b1;
        else if (m_since_jump == 0 && m_vec == i) nxt[i] = 1'b0;
        else                                      nxt[i] = m_pend[i];
      end
      if (m_since_jump < 0) begin
        if (req != 0) begin
          m_since_jump = 0;
          m_vec = lowest_set(req);
        end
      end else if (m_since_jump == 0) begin
        m_since_jump = 1;
      end else if (ret) begin
        m_since_jump = -1;
      end else begin
        m_since_jump++;
      end
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq_in;
      m_pend = nxt;
    end
    #1;
    if (jump) jumps_seen++;
    if (m_since_jump == 0) model_jumps++;
    check({tag, ".status"},     32'(status),     32'(m_pend));
    check({tag, ".mask"},       32'(mask),       32'(m_mask));
    check({tag, ".jump"},       32'(jump),       32'(m_since_jump == 0));
    check({tag, ".in_service"}, 32'(in_service), 32'(m_since_jump >= 0));
    check({tag, ".vector"},     32'(vector),     32'(m_vec));
    $display("step %-10s irq=%02h st=%02h mk=%02h jump=%0d vec=%0d insvc=%0d",
             tag, irq_in, status, mask, jump, vector, in_service);
  endtask

  initial begin
    rst = 1'b0; irq_in = 8'hFF; mask_we = 0; mask_wdata = 0;
    clear_we = 0; clear_mask = 0; ret = 0;
    jumps_seen = 0; model_jumps = 0;

    // Reset with all sources asserted.
    step("rst0"); step("rst1");
    check("rst.status", 32'(status), 32'h00);
    check("rst.mask",   32'(mask),   32'hFF);
    check("rst.jump",   32'(jump),   32'h0);
    check("rst.insvc",  32'(in_service), 32'h0);
    #3 rst = 1'b1;
    step("rel1");
    check("rel1.jump", 32'(jump), 32'h0);
    step("rel2");
    check("rel2.jump", 32'(jump), 32'h1);
    check("rel2.vec",  32'(vector), 32'h0);
    #3 irq_in = 8'h00; clear_we = 1; clear_mask = 8'hFF;
    step("rclr");
    #3 clear_we = 0; ret = 1;
    step("rret");
    #3 ret = 0;
    step("ridle");
    check("ridle.status", 32'(status), 32'h00);

    // Priority: sources 5 and 7 together.
    #3 irq_in = 8'hA0;
    step("pr_set");
    #3 irq_in = 8'h00;
    step("pr_j5");
    check("pr.jump5", 32'(jump), 32'h1);
    check("pr.vec5",  32'(vector), 32'd5);
    step("pr_svc");
    check("pr.pend7", 32'(status), 32'h80);
    #3 ret = 1; step("pr_ret1");
    #3 ret = 0; step("pr_j7");
    check("pr.jump7", 32'(jump), 32'h1);
    check("pr.vec7",  32'(vector), 32'd7);
    step("pr_svc7");
    #3 ret = 1; step("pr_ret2");
    #3 ret = 0; step("pr_idle1"); step("pr_idle2");
    check("pr.empty",  32'(status), 32'h00);
    check("pr.nojump", 32'(jump), 32'h0);

    // Mask gates arbitration but not pending.
    #3 mask_we = 1; mask_wdata = 8'hFE; step("mk_wr");
    #3 mask_we = 0; irq_in = 8'h01; step("mk_irq");
    #3 irq_in = 8'h00; step("mk_w1"); step("mk_w2");
    check("mk.pend0",  32'(status[0]), 32'h1);
    check("mk.nojump", 32'(in_service), 32'h0);
    #3 mask_we = 1; mask_wdata = 8'hFF; step("mk_en");
    #3 mask_we = 0; step("mk_j0");
    check("mk.jump", 32'(jump), 32'h1);
    check("mk.vec",  32'(vector), 32'h0);
    step("mk_svc");
    #3 ret = 1; step("mk_ret");
    #3 ret = 0;

    // Clear beats a simultaneous set.
    #3 clear_we = 1; clear_mask = 8'h04; irq_in = 8'h04; step("cs_both");
    check("cs.pend2", 32'(status[2]), 32'h0);
    #3 clear_we = 0; irq_in = 8'h00; step("cs_w1"); step("cs_w2");
    check("cs.nojump", 32'(in_service), 32'h0);

    // A request arriving mid-service waits for ret.
    #3 irq_in = 8'h01; step("sh_set");
    #3 irq_in = 8'h00; step("sh_j0"); step("sh_svc");
    #3 irq_in = 8'h02; step("sh_irq1");
    #3 irq_in = 8'h00; step("sh_hold1"); step("sh_hold2");
    check("sh.hold_jump", 32'(jump), 32'h0);
    check("sh.hold_svc",  32'(in_service), 32'h1);
    #3 ret = 1; step("sh_ret");
    #3 ret = 0; step("sh_j1");
    check("sh.jump1", 32'(jump), 32'h1);
    check("sh.vec1",  32'(vector), 32'h1);
    step("sh_svc1");
    #3 ret = 1; step("sh_ret1");
    step("sh_idle_ret");
    check("sh.idle_ret", 32'(in_service), 32'h0);
    #3 ret = 0;

    // Held source 3 for 20 cycles, returning whenever servicing.
    jumps_seen = 0; model_jumps = 0;
    #3 irq_in = 8'h08;
    for (int c = 0; c < 20; c++) begin
      step("hold3");
      if (jump) check("hold.vec3", 32'(vector), 32'd3);
      #3 ret = in_service && !jump;
    end
`ifdef INTERRUPT_CTRL_EDGE_DETECT_EN
    check("hold.jumps_edge", 32'(jumps_seen), 32'd1);
`else
    check("hold.jumps_level", 32'(jumps_seen >= 2), 32'h1);
`endif
    check("hold.jumps_model", 32'(jumps_seen), 32'(model_jumps));
    #3 irq_in = 8'h00; clear_we = 1; clear_mask = 8'hFF; ret = 1;
    for (int c = 0; c < 4; c++) step("drain");
    #3 clear_we = 0; ret = 0;

    // Randomised traffic including occasional resets and mask writes.
    for (int c = 0; c < 400; c++) begin
      #3;
      rst        = ($urandom_range(0, 63) != 0);
      irq_in     = ($urandom_range(0, 3) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00;
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom);
      clear_we   = ($urandom_range(0, 7) == 0);
      clear_mask = 8'($urandom);
      ret        = ($urandom_range(0, 2) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
